lfsr_rng: RTL and testbench
===========================

LFSR_RNG -- requirements
Module: lfsr_rng

Interface
REQ-001 Parameter S_WIDTH, default 8: LFSR state and output width, legal range 4..32.
REQ-002 Parameter TAPS, default 8'hB8: Galois feedback mask, S_WIDTH bits (x^8+x^6+x^5+x^4+1 at default).
REQ-003 Parameter INT_WIDTH, default 2: number of low bits kept in mode 01.
REQ-004 Parameter WARMUP, default S_WIDTH: LFSR steps discarded after each seed, legal range 0..255.
REQ-005 Parameter DEFAULT_SEED, default 1: nonzero substitute for an all-zero seed.
REQ-006 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst_i  input  1  asynchronous, active-low reset.
REQ-008 seed_valid_i  input  1  load seed_i this cycle.
REQ-009 seed_i  input  S_WIDTH  seed value.
REQ-010 mode_i  input  2  00 full range, 01 0..2^INT_WIDTH-1, 10 nonzero 1..2^S_WIDTH-1, 11 bounded 0..bound_i-1.
REQ-011 bound_i  input  S_WIDTH  exclusive upper bound for mode 11.
REQ-012 rnd_valid_o  output  1  rnd_o holds an unconsumed number.
REQ-013 rnd_ready_i  input  1  consumer accepts rnd_o.
REQ-014 rnd_o  output  S_WIDTH  random number, zero-extended in modes 01/11.
REQ-015 seeded_o  output  1  high in RUN.

Function
REQ-016 FSM states: IDLE (unseeded), WARMUP, RUN; reset enters IDLE.
REQ-017 Step: s_next = (s >> 1) ^ (s[0] ? TAPS : 0).
REQ-018 seed_valid_i has priority in every state: s <= (seed_i == 0 ? DEFAULT_SEED : seed_i), rnd_valid_o <= 0, warm-up counter <= WARMUP, next state WARMUP (RUN if WARMUP == 0).
REQ-019 WARMUP: one step per cycle, counter decrements; at count 1 go to RUN; no output.
REQ-020 load = RUN && (!rnd_valid_o || rnd_ready_i) && !seed_valid_i; the LFSR steps only on load cycles in RUN.
REQ-021 On load, candidate from current s and current mode_i/bound_i: mode 00 cand = s; mode 01 cand = s[INT_WIDTH-1:0]; mode 10 cand = s (never zero by construction); mode 11 see REQ-022.
REQ-022 Mode 11: mask = smallest 2^k-1 >= bound_i-1; m = s & mask; accept iff m < bound_i; bound_i 0 or 1 -> cand 0, always accepted.
REQ-023 Accepted load: rnd_o <= cand, rnd_valid_o <= 1; rejected load: rnd_valid_o <= 0, retry next cycle.
REQ-024 Load latency 1 cycle; with rnd_ready_i held high and no rejections, one number per cycle.
REQ-025 While rnd_valid_o && !rnd_ready_i, rnd_o and s hold; mode_i/bound_i changes affect only later loads.
REQ-026 Lock-up is impossible: the zero state is never loaded.

Reset
REQ-027 Asynchronous assertion, synchronous deassertion handled externally: s <= DEFAULT_SEED, counter <= 0, state IDLE, rnd_o <= 0, rnd_valid_o <= 0, seeded_o <= 0.
REQ-028 Reset mid-WARMUP or mid-handshake discards any pending number with no further valid pulse.

Structure
REQ-029 Shared package holds the mode encodings (MODE_FULL, MODE_LOW, MODE_NONZERO, MODE_BOUNDED), the FSM state encoding and the default TAPS per width (8, 16, 32).
REQ-030 The mask-and-compare rejection logic shall be one combinational sub-module, rng_range_filter.

Verification (S_WIDTH=8, TAPS=B8, WARMUP=0 unless stated)
REQ-031 Seed 0x01, mode 00, ready high -> rnd_o 01, B8, 5C, 2E, 17, B3 on consecutive cycles.
REQ-032 Seed 0x00 -> sequence identical to seed 0x01; over 255 outputs all nonzero values appear exactly once, then the sequence repeats.
REQ-033 Seed 0x01, mode 11, bound 5 -> accepted 1, 0, 4, 3; valid low for the two cycles of states 2E and 17; never >= 5.
REQ-034 Ready low for 3 cycles after first output -> rnd_o stays 01, valid stays high; next value B8 after ready rises.
REQ-035 WARMUP=8, seed 0x01 -> seeded_o rises after 8 cycles; first output equals the 9th state of REQ-031's sequence; rst_i low during warm-up -> IDLE with valid 0.
REQ-036 Seed pulse while valid and ready low -> valid drops the next cycle; the new sequence starts from the new seed.

Source files
------------

// File: rtl/lfsr_rng_pkg.sv
// Shared definitions for the LFSR random number generator: mode encodings,
// FSM state encoding and default Galois tap masks.
package lfsr_rng_pkg;

  localparam logic [1:0] MODE_FULL    = 2'b00;
  localparam logic [1:0] MODE_LOW     = 2'b01;
  localparam logic [1:0] MODE_NONZERO = 2'b10;
  localparam logic [1:0] MODE_BOUNDED = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } rng_state_e;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;

  // Maximal-length masks for the common widths; other widths get a simple
  // two-tap mask and should override TAPS explicitly.
  function automatic logic [31:0] default_taps(input int width);
    case (width)
      8:       return {24'h0, TAPS_8};
      16:      return {16'h0, TAPS_16};
      32:      return TAPS_32;
      default: return (32'h1 << (width - 1)) | 32'h1;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_rng_if.sv
// Seed/mode inputs and the random-number output handshake of lfsr_rng.
// Handshake: a number transfers on a rising edge where rnd_valid_o && rnd_ready_i;
// while rnd_valid_o is high and rnd_ready_i low, rnd_o holds and valid stays high.
interface lfsr_rng_if #(
  parameter int S_WIDTH = 8
);
  logic               seed_valid_i;
  logic [S_WIDTH-1:0] seed_i;
  logic [1:0]         mode_i;
  logic [S_WIDTH-1:0] bound_i;
  logic               rnd_valid_o;
  logic               rnd_ready_i;
  logic [S_WIDTH-1:0] rnd_o;
  logic               seeded_o;

  modport master (
    output seed_valid_i, seed_i, mode_i, bound_i, rnd_ready_i,
    input  rnd_valid_o, rnd_o, seeded_o
  );

  modport slave (
    input  seed_valid_i, seed_i, mode_i, bound_i, rnd_ready_i,
    output rnd_valid_o, rnd_o, seeded_o
  );
endinterface

// File: rtl/rng_range_filter.sv
// Bounded-mode rejection filter: masks the LFSR state down to the smallest
// all-ones mask covering bound-1 and accepts only values below the bound.
module rng_range_filter #(
  parameter int W = 8
) (
  input  logic [W-1:0] value_i,
  input  logic [W-1:0] bound_i,
  output logic [W-1:0] cand_o,
  output logic         accept_o
);

  logic [W-1:0] bound_m1;
  logic [W-1:0] mask;
  logic [W-1:0] masked;

  always_comb begin
    bound_m1 = bound_i - W'(1);
    mask     = '0;
    // Bit i of the mask is set when bound-1 has any set bit at or above i.
    for (int i = 0; i < W; i++) begin
      mask[i] = |(bound_m1 >> i);
    end
    masked = value_i & mask;
    if (bound_i < W'(2)) begin
      cand_o   = '0;
      accept_o = 1'b1;
    end else begin
      cand_o   = masked;
      accept_o = (masked < bound_i);
    end
  end

endmodule

// File: rtl/lfsr_rng.sv
// Galois LFSR random number generator with seeding, warm-up, output shaping
// modes and a valid/ready output handshake.
module lfsr_rng
  import lfsr_rng_pkg::*;
#(
  parameter int                 S_WIDTH      = 8,
  parameter logic [S_WIDTH-1:0] TAPS         = S_WIDTH'(default_taps(S_WIDTH)),
  parameter int                 INT_WIDTH    = 2,
  parameter int                 WARMUP       = S_WIDTH,
  parameter logic [S_WIDTH-1:0] DEFAULT_SEED = S_WIDTH'(1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  lfsr_rng_if.slave           bus,
  output rng_state_e          state_o
);

  localparam logic [S_WIDTH-1:0] LOW_MASK = S_WIDTH'((64'd1 << INT_WIDTH) - 64'd1);

  rng_state_e         state_q, state_d;
  logic [S_WIDTH-1:0] s_q, s_d, s_step;
  logic [7:0]         cnt_q, cnt_d;
  logic [S_WIDTH-1:0] rnd_q, rnd_d;
  logic               valid_q, valid_d;
  logic               load;
  logic [S_WIDTH-1:0] cand, f_cand;
  logic               accept, f_accept;

  rng_range_filter #(.W(S_WIDTH)) u_filter (
    .value_i  (s_q),
    .bound_i  (bus.bound_i),
    .cand_o   (f_cand),
    .accept_o (f_accept)
  );

  assign s_step = (s_q >> 1) ^ (s_q[0] ? TAPS : '0);

  always_comb begin
    cand   = s_q;
    accept = 1'b1;
    case (bus.mode_i)
      MODE_LOW:     cand = s_q & LOW_MASK;
      MODE_BOUNDED: begin
        cand   = f_cand;
        accept = f_accept;
      end
      default:      cand = s_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    rnd_d   = rnd_q;
    valid_d = valid_q;
    load    = (state_q == ST_RUN) && (!valid_q || bus.rnd_ready_i) && !bus.seed_valid_i;
    if (bus.seed_valid_i) begin
      // A zero seed would lock the LFSR up, so it is replaced.
      s_d     = (bus.seed_i == '0) ? DEFAULT_SEED : bus.seed_i;
      valid_d = 1'b0;
      cnt_d   = 8'(WARMUP);
      state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          s_d   = s_step;
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (load) begin
            s_d = s_step;
            if (accept) begin
              rnd_d   = cand;
              valid_d = 1'b1;
            end else begin
              valid_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      s_q     <= DEFAULT_SEED;
      cnt_q   <= 8'd0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
    end
  end

  assign bus.rnd_o       = rnd_q;
  assign bus.rnd_valid_o = valid_q;
  assign bus.seeded_o    = (state_q == ST_RUN);
  assign state_o         = state_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Self-checking bench for lfsr_rng: directed sequences plus randomized
// traffic against a transaction-level reference model.
module tb_lfsr_rng;
  import lfsr_rng_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  lfsr_rng_if #(.S_WIDTH(W)) bus0 ();
  lfsr_rng_if #(.S_WIDTH(W)) bus8 ();
  rng_state_e state0, state8;

  lfsr_rng #(.S_WIDTH(8), .TAPS(8'hB8), .INT_WIDTH(2), .WARMUP(0), .DEFAULT_SEED(8'h01)) dut0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bus     (bus0),
    .state_o (state0)
  );

  lfsr_rng #(.S_WIDTH(8), .TAPS(8'hB8), .INT_WIDTH(2), .WARMUP(8), .DEFAULT_SEED(8'h01)) dut8 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bus     (bus8),
    .state_o (state8)
  );

  // ---------------- scoreboard / model state ----------------
  int compares = 0;
  int fails    = 0;
  logic [W-1:0] exp_q[$];

  logic [W-1:0] m_s     = 8'h01;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_rnd   = 8'h00;
  logic         m_run   = 1'b0;

  function automatic logic [W-1:0] nxt(input logic [W-1:0] s);
    return (s / 2) ^ (((s % 2) == 1) ? 8'hB8 : 8'h00);
  endfunction

  function automatic logic [W-1:0] nth_state(input logic [W-1:0] seed, input int n);
    logic [W-1:0] s;
    s = seed;
    for (int i = 0; i < n; i++) s = nxt(s);
    return s;
  endfunction

  task automatic ref_cand(input logic [W-1:0] s, input logic [1:0] mode, input logic [W-1:0] bound,
                          output logic [W-1:0] c, output logic a);
    int span;
    a = 1'b1;
    case (mode)
      2'b01: c = s % 4;
      2'b11: begin
        if (bound < 2) begin
          c = 0;
        end else begin
          span = 1 << $clog2(int'(bound));
          c    = s % span;
          a    = (int'(c) < int'(bound));
        end
      end
      default: c = s;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus0.seed_valid_i = 0; bus0.seed_i = 0; bus0.mode_i = 0; bus0.bound_i = 0; bus0.rnd_ready_i = 0;
    bus8.seed_valid_i = 0; bus8.seed_i = 0; bus8.mode_i = 0; bus8.bound_i = 0; bus8.rnd_ready_i = 0;
  endtask

  // Advance one clock on dut0 while updating the reference model from the
  // inputs presented before the edge.
  task automatic cycle0();
    logic [W-1:0] c;
    logic a;
    if (bus0.seed_valid_i) begin
      m_s     = (bus0.seed_i == 0) ? 8'h01 : bus0.seed_i;
      m_valid = 0;
      m_run   = 1;
    end else if (m_run && (!m_valid || bus0.rnd_ready_i)) begin
      ref_cand(m_s, bus0.mode_i, bus0.bound_i, c, a);
      if (a) begin
        m_rnd   = c;
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
      m_s = nxt(m_s);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic seed0(input logic [W-1:0] seed);
    bus0.seed_valid_i = 1; bus0.seed_i = seed;
    cycle0();
    bus0.seed_valid_i = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    compares++; if (bus0.rnd_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", bus0.rnd_valid_o); end
    compares++; if (bus0.rnd_o !== 8'h00) begin fails++; $display("FAIL reset_rnd got %h want 00", bus0.rnd_o); end
    compares++; if (bus0.seeded_o !== 1'b0) begin fails++; $display("FAIL reset_seeded got %0b want 0", bus0.seeded_o); end
    compares++; if (state0 !== ST_IDLE) begin fails++; $display("FAIL reset_state got %0d want %0d", state0, ST_IDLE); end
    rst_i = 1;
    repeat (3) cycle0();
    compares++; if (bus0.rnd_valid_o !== 1'b0) begin fails++; $display("FAIL idle_no_output got %0b want 0", bus0.rnd_valid_o); end
  endtask

  task automatic test_sequence();
    logic [W-1:0] spec_seq [6];
    spec_seq = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    bus0.mode_i = MODE_FULL; bus0.rnd_ready_i = 1;
    seed0(8'h01);
    compares++; if (bus0.seeded_o !== 1'b1) begin fails++; $display("FAIL seq_seeded got %0b want 1", bus0.seeded_o); end
    compares++; if (bus0.rnd_valid_o !== 1'b0) begin fails++; $display("FAIL seq_latency got %0b want 0", bus0.rnd_valid_o); end
    for (int i = 0; i < 6; i++) begin
      cycle0();
      compares++;
      if (bus0.rnd_valid_o !== 1'b1 || bus0.rnd_o !== spec_seq[i] || m_rnd !== spec_seq[i]) begin
        fails++; $display("FAIL seq[%0d] got v=%0b %h want v=1 %h", i, bus0.rnd_valid_o, bus0.rnd_o, spec_seq[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bus0.mode_i = MODE_FULL; bus0.rnd_ready_i = 0;
    seed0(8'h01);
    cycle0();
    compares++; if (bus0.rnd_valid_o !== 1'b1 || bus0.rnd_o !== 8'h01) begin fails++; $display("FAIL bp_first got v=%0b %h want v=1 01", bus0.rnd_valid_o, bus0.rnd_o); end
    for (int i = 0; i < 3; i++) begin
      cycle0();
      compares++;
      if (bus0.rnd_valid_o !== 1'b1 || bus0.rnd_o !== 8'h01) begin
        fails++; $display("FAIL bp_hold[%0d] got v=%0b %h want v=1 01", i, bus0.rnd_valid_o, bus0.rnd_o);
      end
    end
    bus0.rnd_ready_i = 1;
    cycle0();
    compares++; if (bus0.rnd_valid_o !== 1'b1 || bus0.rnd_o !== 8'hB8) begin fails++; $display("FAIL bp_next got v=%0b %h want v=1 b8", bus0.rnd_valid_o, bus0.rnd_o); end
  endtask

  task automatic test_reseed();
    bus0.rnd_ready_i = 0;
    cycle0();
    bus0.seed_valid_i = 1; bus0.seed_i = 8'h5A;
    cycle0();
    bus0.seed_valid_i = 0;
    compares++; if (bus0.rnd_valid_o !== 1'b0) begin fails++; $display("FAIL reseed_drop got %0b want 0", bus0.rnd_valid_o); end
    bus0.rnd_ready_i = 1;
    cycle0();
    compares++; if (bus0.rnd_valid_o !== 1'b1 || bus0.rnd_o !== 8'h5A) begin fails++; $display("FAIL reseed_first got v=%0b %h want v=1 5a", bus0.rnd_valid_o, bus0.rnd_o); end
    cycle0();
    compares++; if (bus0.rnd_o !== 8'h2D || m_rnd !== 8'h2D) begin fails++; $display("FAIL reseed_second got %h want 2d", bus0.rnd_o); end
  endtask

  task automatic test_bounded();
    logic       exp_v [6];
    logic [W-1:0] exp_r [6];
    exp_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_r = '{8'd1, 8'd0, 8'd4, 8'd4, 8'd4, 8'd3};
    bus0.mode_i = MODE_BOUNDED; bus0.bound_i = 8'd5; bus0.rnd_ready_i = 1;
    seed0(8'h01);
    for (int i = 0; i < 6; i++) begin
      cycle0();
      compares++;
      if (bus0.rnd_valid_o !== exp_v[i] || (exp_v[i] && bus0.rnd_o !== exp_r[i])) begin
        fails++; $display("FAIL bounded[%0d] got v=%0b %0d want v=%0b %0d", i, bus0.rnd_valid_o, bus0.rnd_o, exp_v[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_period();
    bit seen [256];
    int distinct;
    logic [W-1:0] exp;
    for (int i = 0; i < 256; i++) seen[i] = 0;
    for (int i = 0; i < 255; i++) exp_q.push_back(nth_state(8'h01, i));
    exp_q.push_back(8'h01);
    bus0.mode_i = MODE_FULL; bus0.rnd_ready_i = 1;
    seed0(8'h00);
    distinct = 0;
    for (int i = 0; i < 256; i++) begin
      cycle0();
      exp = exp_q.pop_front();
      compares++;
      if (bus0.rnd_valid_o !== 1'b1 || bus0.rnd_o !== exp) begin
        fails++; $display("FAIL period[%0d] got v=%0b %h want v=1 %h", i, bus0.rnd_valid_o, bus0.rnd_o, exp);
      end
      if (i < 255 && !seen[bus0.rnd_o]) begin
        seen[bus0.rnd_o] = 1;
        if (bus0.rnd_o != 0) distinct++;
      end
    end
    compares++; if (distinct != 255) begin fails++; $display("FAIL period_distinct got %0d want 255", distinct); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        bus0.seed_valid_i = 1; bus0.seed_i = W'($urandom_range(0, 255));
      end else begin
        bus0.seed_valid_i = 0;
      end
      if ($urandom_range(0, 7) == 0) bus0.mode_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) bus0.bound_i = W'($urandom_range(0, 255));
      bus0.rnd_ready_i = 1'($urandom_range(0, 1));
      cycle0();
      compares++;
      if (bus0.rnd_valid_o !== m_valid || bus0.rnd_o !== m_rnd || bus0.seeded_o !== m_run) begin
        fails++; $display("FAIL random[%0d] got v=%0b %h s=%0b want v=%0b %h s=%0b",
                          i, bus0.rnd_valid_o, bus0.rnd_o, bus0.seeded_o, m_valid, m_rnd, m_run);
      end
    end
    bus0.seed_valid_i = 0;
  endtask

  task automatic test_warmup();
    logic [W-1:0] exp;
    exp = nth_state(8'h01, 8);
    bus8.mode_i = MODE_FULL; bus8.rnd_ready_i = 1;
    bus8.seed_valid_i = 1; bus8.seed_i = 8'h01;
    @(posedge clk_i); #1;
    bus8.seed_valid_i = 0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk_i); #1;
      compares++;
      if (bus8.seeded_o !== 1'b0 || bus8.rnd_valid_o !== 1'b0) begin
        fails++; $display("FAIL warm[%0d] got seeded=%0b v=%0b want 0 0", i, bus8.seeded_o, bus8.rnd_valid_o);
      end
    end
    @(posedge clk_i); #1;
    compares++; if (bus8.seeded_o !== 1'b1) begin fails++; $display("FAIL warm_seeded got %0b want 1", bus8.seeded_o); end
    @(posedge clk_i); #1;
    compares++; if (bus8.rnd_valid_o !== 1'b1 || bus8.rnd_o !== exp) begin fails++; $display("FAIL warm_first got v=%0b %h want v=1 %h", bus8.rnd_valid_o, bus8.rnd_o, exp); end
    // Restart warm-up, then pull reset asynchronously in the middle of it.
    bus8.seed_valid_i = 1;
    @(posedge clk_i); #1;
    bus8.seed_valid_i = 0;
    repeat (3) @(posedge clk_i);
    #3 rst_i = 0;
    #1;
    compares++; if (state8 !== ST_IDLE || bus8.rnd_valid_o !== 1'b0 || bus8.seeded_o !== 1'b0) begin
      fails++; $display("FAIL warm_reset got st=%0d v=%0b s=%0b want %0d 0 0", state8, bus8.rnd_valid_o, bus8.seeded_o, ST_IDLE);
    end
    @(posedge clk_i); #1;
    rst_i = 1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_i); #1;
      compares++;
      if (bus8.rnd_valid_o !== 1'b0) begin fails++; $display("FAIL warm_after_reset[%0d] got v=%0b want 0", i, bus8.rnd_valid_o); end
    end
  endtask

  // ---------------- sequence / final report ----------------
  initial begin
    test_reset();
    test_sequence();
    test_backpressure();
    test_reseed();
    test_bounded();
    test_period();
    test_random();
    test_warmup();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
